// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU flag pipeline.
// Holds the operation selector encoding and the bit positions inside the NZCV register.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_PASS_B = 2'd0,
    ALU_PASS_A = 2'd1,
    ALU_ZERO   = 2'd2,
    ALU_NOT_B  = 2'd3
  } alu_pass_mode_t;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

endpackage

// File: rtl/zero_chunk_reduce.sv
// OR-reduces each CHUNK-bit slice of the input; the final zero flag is the NOR of these bits.
// Purely combinational, so a wide zero-detect can be split across a register boundary.
module zero_chunk_reduce #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic [WIDTH-1:0]       i_dat,
  output logic [WIDTH/CHUNK-1:0] o_chunk_or
);

  localparam int NCH = WIDTH / CHUNK;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("zero_chunk_reduce: WIDTH must be a multiple of CHUNK");
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    assign o_chunk_or[g] = |i_dat[g*CHUNK +: CHUNK];
  end

endmodule

// File: rtl/alu_flag_pipe.sv
// Two-stage valid/ready ALU pass-through pipe producing N/Z flags and an architectural NZCV register.
// S1 holds the result plus per-chunk OR bits, S2 holds the result with final flags; 2-cycle latency.
module alu_flag_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       nzcv
);

  localparam int NCH = WIDTH / CHUNK;

  if (WIDTH < 8 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("alu_flag_pipe: WIDTH must be >= 8 and a multiple of CHUNK");
  end

  logic [WIDTH-1:0] w_res;
  logic [NCH-1:0]   w_chunk_or;
  logic             w_out_xfer;
  logic             w_s2_load;
  logic             w_s1_load;

  logic             r_s1_vld;
  logic [WIDTH-1:0] r_s1_res;
  logic             r_s1_setf;
  logic [NCH-1:0]   r_s1_chunk;

  logic             r_s2_vld;
  logic [WIDTH-1:0] r_s2_res;
  logic             r_s2_neg;
  logic             r_s2_zero;
  logic             r_s2_setf;

  logic [3:0]       r_nzcv;

  always_comb begin
    w_res = '0;
    case (alu_pass_mode_t'(mode))
      ALU_PASS_B: w_res = b;
      ALU_PASS_A: w_res = a;
      ALU_ZERO:   w_res = '0;
      ALU_NOT_B:  w_res = ~b;
      default:    w_res = '0;
    endcase
  end

  zero_chunk_reduce #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) u_zero_chunk_reduce (
    .i_dat      (w_res),
    .o_chunk_or (w_chunk_or)
  );

  // S2 can take new data when empty or when its current entry leaves this cycle.
  assign w_out_xfer = r_s2_vld & out_ready;
  assign w_s2_load  = ~r_s2_vld | out_ready;
  assign w_s1_load  = ~r_s1_vld | w_s2_load;
  assign in_ready   = reset_n & w_s1_load;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_res   <= '0;
      r_s1_setf  <= 1'b0;
      r_s1_chunk <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_res   <= '0;
      r_s2_neg   <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_setf  <= 1'b0;
      r_nzcv     <= 4'b0000;
    end else begin
      if (w_s1_load) begin
        r_s1_vld <= in_valid;
        if (in_valid) begin
          r_s1_res   <= w_res;
          r_s1_setf  <= set_flags;
          r_s1_chunk <= w_chunk_or;
        end
      end
      if (w_s2_load) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_res  <= r_s1_res;
          r_s2_neg  <= r_s1_res[WIDTH-1];
          r_s2_zero <= ~|r_s1_chunk;
          r_s2_setf <= r_s1_setf;
        end
      end
      // C and V are never produced by these modes, so they simply keep their value.
      if (w_out_xfer && r_s2_setf) begin
        r_nzcv[NZCV_N] <= r_s2_neg;
        r_nzcv[NZCV_Z] <= r_s2_zero;
      end
    end
  end

  assign out_valid = r_s2_vld;
  assign result    = r_s2_res;
  assign negative  = r_s2_neg;
  assign zero      = r_s2_zero;
  assign overflow  = 1'b0;
  assign carry_out = 1'b0;
  assign nzcv      = r_nzcv;

endmodule

// File: doc/alu_flag_pipe.md
ALU_FLAG_PIPE -- requirements
Module: alu_flag_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits (>= 8).
REQ-002 SHALL have parameter CHUNK, default 16, zero-detect partial width; WIDTH SHALL be a multiple of CHUNK (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  upstream operation present.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 mode  input  2  PASS_B=0, PASS_A=1, ZERO=2, NOT_B=3.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 set_flags  input  1  operation updates architectural NZCV.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 result  output  WIDTH  selected value.
REQ-013 negative, zero, overflow, carry_out  output  1 each  per-operation flags.
REQ-014 nzcv  output  4  architectural flag register, bit3=N, bit2=Z, bit1=C, bit0=V.

Function
REQ-015 result SHALL be b (PASS_B), a (PASS_A), all-zeros (ZERO), ~b (NOT_B).
REQ-016 negative SHALL equal result[WIDTH-1]; zero SHALL be 1 iff result is all-zeros; overflow and carry_out SHALL be 0 in every mode.
REQ-017 Two-stage pipeline: S1 registers result, set_flags, and WIDTH/CHUNK chunk-OR bits; S2 registers result, final zero (NOR of chunk bits), negative, set_flags.
REQ-018 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-019 Stage advance: S2 loads when S2 empty or output transfer occurs; S1 loads when S1 empty or S1 moves to S2; in_ready SHALL equal that S1-load condition (combinational from out_ready allowed).
REQ-020 Latency: operation accepted in cycle t SHALL present out_valid in cycle t+2 with no backpressure; throughput one operation per cycle sustained.
REQ-021 While out_valid && !out_ready, result and all flag outputs SHALL hold stable; no operation dropped or duplicated; with both stages full and out_ready=0, in_ready SHALL be 0.
REQ-022 nzcv SHALL update only on output transfer of an operation with set_flags=1: N<=negative, Z<=zero, C and V retained.
REQ-023 Output transfer with set_flags=0 SHALL leave nzcv unchanged.
REQ-024 Simultaneous input and output transfer in a full pipeline SHALL be lossless and keep order.

Reset
REQ-025 With reset_n=0 at a clock edge: S1/S2 valid, out_valid, result, negative, zero, overflow, carry_out and nzcv SHALL all become 0.
REQ-026 in_ready SHALL be 0 while reset_n=0; reset mid-operation SHALL discard in-flight operations without nzcv update.
REQ-027 First acceptance possible in the first cycle after reset_n returns to 1.

Structure
REQ-028 Package alu_pkg SHALL hold the mode enum (alu_pass_mode_t) and NZCV bit-index constants.
REQ-029 Chunked zero reduction SHALL be a sub-module zero_chunk_reduce (parameters WIDTH, CHUNK; output one OR bit per chunk).
REQ-030 Target size 120-400 lines RTL total.

Verification
REQ-031 WIDTH=64: PASS_B, b=0x8000_0000_0000_0000, set_flags=1, out_ready=1 -> cycle t+2 result=0x8000_0000_0000_0000, negative=1, zero=0; nzcv=4'b1000 after transfer.
REQ-032 ZERO mode, set_flags=1, nzcv preloaded 4'b0011 via prior state -> zero=1, negative=0, nzcv=4'b0111 (C,V retained).
REQ-033 NOT_B, b=0xFFFF_FFFF_FFFF_FFFF, set_flags=0 -> result=0, zero=1, nzcv unchanged.
REQ-034 Back-to-back 4 ops with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 emerge in order once out_ready=1.
REQ-035 reset_n=0 with both stages full -> next cycle out_valid=0, nzcv=0, no output transfer.
REQ-036 WIDTH=32, CHUNK=8: b=0x0000_0100 PASS_B -> zero=0; b=0 -> zero=1.
